// File: rtl/trap_filter_ctrl.sv
// trap_filter_ctrl: run-time sequencer for the trapezoidal filter datapath.
// Holds K/L/mult config, sequences filter reset/prefill, gates output valid.
//
// Ports:
//   clk, areset        clock, asynchronous active-high reset
//   run_en             level request for the filter to run
//   cfg_req            config request, one accept per low->high episode
//   cfg_kdelay/ldelay  requested K and L delays
//   cfg_mult           requested signed decay multiplier
//   cfg_ack, cfg_err   one-cycle accept / reject pulses
//   filt_aresetn       active-low reset to the filter
//   filt_kdelay/ldelay applied K and L delays
//   filt_mult          applied decay multiplier
//   filt_tvalid        filter output valid
//   m_axis_tvalid      valid gated to settled trapezoid data only
//   state              0 IDLE, 1 RESET, 2 FILL, 3 RUN
module trap_filter_ctrl #(
    parameter int DELAY_WIDTH = 14,
    parameter int MULT_WIDTH  = 16,
    parameter int DEF_K       = 10,
    parameter int DEF_L       = 20,
    parameter int DEF_MULT    = 0,
    parameter int RST_CYCLES  = 4,
    parameter int PIPE_LAT    = 6
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   run_en,
    input  logic                   cfg_req,
    input  logic [DELAY_WIDTH-1:0] cfg_kdelay,
    input  logic [DELAY_WIDTH-1:0] cfg_ldelay,
    input  logic [MULT_WIDTH-1:0]  cfg_mult,
    output logic                   cfg_ack,
    output logic                   cfg_err,
    output logic                   filt_aresetn,
    output logic [DELAY_WIDTH-1:0] filt_kdelay,
    output logic [DELAY_WIDTH-1:0] filt_ldelay,
    output logic [MULT_WIDTH-1:0]  filt_mult,
    input  logic                   filt_tvalid,
    output logic                   m_axis_tvalid,
    output logic [1:0]             state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [15:0] FILL_EXTRA = 16'(2 + PIPE_LAT);

    localparam logic [DELAY_WIDTH-1:0] K_DEF = DELAY_WIDTH'(DEF_K);
    localparam logic [DELAY_WIDTH-1:0] L_DEF = DELAY_WIDTH'(DEF_L);
    localparam logic [MULT_WIDTH-1:0]  M_DEF = MULT_WIDTH'(DEF_MULT);
    localparam logic [DELAY_WIDTH-1:0] K_MIN = DELAY_WIDTH'(3);

    logic [1:0]             r_state;
    logic                   r_aresetn;
    logic                   r_ack;
    logic                   r_err;
    logic                   r_armed;
    logic [7:0]             r_rst_cnt;
    logic [15:0]            r_fill_cnt;
    logic [DELAY_WIDTH-1:0] r_pend_k;
    logic [DELAY_WIDTH-1:0] r_pend_l;
    logic [MULT_WIDTH-1:0]  r_pend_m;
    logic [DELAY_WIDTH-1:0] r_filt_k;
    logic [DELAY_WIDTH-1:0] r_filt_l;
    logic [MULT_WIDTH-1:0]  r_filt_m;

    logic        w_cfg_new;
    logic        w_cfg_ok;
    logic        w_accept;
    logic        w_reject;
    logic        w_load_filt;
    logic [15:0] w_fill_len;
    logic        w_fill_done;

    // A request is only evaluated on the first sampled-high edge of an episode.
    assign w_cfg_new = cfg_req & r_armed;
    assign w_cfg_ok  = (cfg_kdelay >= K_MIN) & (cfg_ldelay >= cfg_kdelay);
    assign w_accept  = w_cfg_new & w_cfg_ok;
    assign w_reject  = w_cfg_new & ~w_cfg_ok;

    // Parameters move only while the filter is held in reset: every IDLE
    // cycle, and at the end of the first RESET cycle so a restart picks up
    // the config accepted on the edge that entered RESET.
    assign w_load_filt = (r_state == S_IDLE)
                       | ((r_state == S_RESET) & (r_rst_cnt == 8'd0));

    // Prefill of both delay lines plus the arithmetic pipeline.
    assign w_fill_len  = 16'(r_filt_k) + 16'(r_filt_l) + FILL_EXTRA;
    assign w_fill_done = (r_fill_cnt == (w_fill_len - 16'd1));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_ack   <= w_accept;
            r_err   <= w_reject;
            r_armed <= ~cfg_req;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_pend_k <= K_DEF;
            r_pend_l <= L_DEF;
            r_pend_m <= M_DEF;
        end else if (w_accept) begin
            r_pend_k <= cfg_kdelay;
            r_pend_l <= cfg_ldelay;
            r_pend_m <= cfg_mult;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_filt_k <= K_DEF;
            r_filt_l <= L_DEF;
            r_filt_m <= M_DEF;
        end else if (w_load_filt) begin
            r_filt_k <= r_pend_k;
            r_filt_l <= r_pend_l;
            r_filt_m <= r_pend_m;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_aresetn  <= 1'b0;
            r_rst_cnt  <= 8'd0;
            r_fill_cnt <= 16'd0;
        end else if (!run_en) begin
            r_state   <= S_IDLE;
            r_aresetn <= 1'b0;
            r_rst_cnt <= 8'd0;
        end else if (w_accept && (r_state != S_IDLE)) begin
            // New config while active: restart the whole sequence.
            r_state   <= S_RESET;
            r_aresetn <= 1'b0;
            r_rst_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state   <= S_RESET;
                    r_aresetn <= 1'b0;
                    r_rst_cnt <= 8'd0;
                end
                S_RESET: begin
                    r_aresetn <= 1'b0;
                    if (r_rst_cnt == RST_LAST) begin
                        r_state    <= S_FILL;
                        r_aresetn  <= 1'b1;
                        r_fill_cnt <= 16'd0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 8'd1;
                    end
                end
                S_FILL: begin
                    r_aresetn <= 1'b1;
                    if (w_fill_done) begin
                        r_state <= S_RUN;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 16'd1;
                    end
                end
                default: begin
                    r_aresetn <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ack       = r_ack;
    assign cfg_err       = r_err;
    assign filt_aresetn  = r_aresetn;
    assign filt_kdelay   = r_filt_k;
    assign filt_ldelay   = r_filt_l;
    assign filt_mult     = r_filt_m;
    assign state         = r_state;
    assign m_axis_tvalid = filt_tvalid & (r_state == S_RUN);

endmodule

// File: tb/tb_trap_filter_ctrl.sv
// tb_trap_filter_ctrl: directed bench for trap_filter_ctrl.
// Config responses are queued when driven and compared when they appear.
module tb_trap_filter_ctrl;

    logic        clk = 1'b0;
    logic        areset;
    logic        run_en;
    logic        cfg_req;
    logic [13:0] cfg_kdelay;
    logic [13:0] cfg_ldelay;
    logic [15:0] cfg_mult;
    logic        cfg_ack;
    logic        cfg_err;
    logic        filt_aresetn;
    logic [13:0] filt_kdelay;
    logic [13:0] filt_ldelay;
    logic [15:0] filt_mult;
    logic        filt_tvalid;
    logic        m_axis_tvalid;
    logic [1:0]  state;

    typedef struct packed {
        logic ack;
        logic err;
    } resp_t;

    resp_t q[$];
    int n_vec = 0;
    int n_err = 0;
    int cnt;

    trap_filter_ctrl dut (
        .clk          (clk),
        .areset       (areset),
        .run_en       (run_en),
        .cfg_req      (cfg_req),
        .cfg_kdelay   (cfg_kdelay),
        .cfg_ldelay   (cfg_ldelay),
        .cfg_mult     (cfg_mult),
        .cfg_ack      (cfg_ack),
        .cfg_err      (cfg_err),
        .filt_aresetn (filt_aresetn),
        .filt_kdelay  (filt_kdelay),
        .filt_ldelay  (filt_ldelay),
        .filt_mult    (filt_mult),
        .filt_tvalid  (filt_tvalid),
        .m_axis_tvalid(m_axis_tvalid),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic measure(input logic [1:0] st, output int n);
        n = 0;
        while (state === st && n < 400) begin
            n++;
            step(1);
        end
    endtask

    task automatic cfg_drive(input logic [13:0] k, input logic [13:0] l,
                             input logic [15:0] m, input logic a,
                             input logic e);
        resp_t r;
        cfg_kdelay = k;
        cfg_ldelay = l;
        cfg_mult   = m;
        cfg_req    = 1'b1;
        r.ack = a;
        r.err = e;
        q.push_back(r);
    endtask

    task automatic cfg_pop(input string tag);
        resp_t r;
        if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed empty queue expected entry", tag);
        end else begin
            r = q.pop_front();
            chk({tag, "_ack"}, 32'(cfg_ack), 32'(r.ack));
            chk({tag, "_err"}, 32'(cfg_err), 32'(r.err));
        end
    endtask

    task automatic chk_filt(input string tag, input int k, input int l,
                            input int m);
        chk({tag, "_k"}, 32'(filt_kdelay), 32'(k));
        chk({tag, "_l"}, 32'(filt_ldelay), 32'(l));
        chk({tag, "_m"}, 32'(filt_mult), 32'(m));
    endtask

    initial begin
        areset      = 1'b1;
        run_en      = 1'b0;
        cfg_req     = 1'b0;
        cfg_kdelay  = 14'd0;
        cfg_ldelay  = 14'd0;
        cfg_mult    = 16'd0;
        filt_tvalid = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_aresetn", 32'(filt_aresetn), 32'd0);
        chk("rst_ack", 32'(cfg_ack), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk_filt("rst_filt", 10, 20, 0);
        step(2);
        areset = 1'b0;
        step(1);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_aresetn", 32'(filt_aresetn), 32'd0);

        // default run
        run_en = 1'b1;
        step(1);
        chk("t2_reset_entry", 32'(state), 32'd1);
        chk("t2_reset_aresetn", 32'(filt_aresetn), 32'd0);
        measure(2'd1, cnt);
        chk("t2_reset_len", 32'(cnt), 32'd4);
        chk("t2_fill_aresetn", 32'(filt_aresetn), 32'd1);
        chk("t2_fill_tvalid", 32'(m_axis_tvalid), 32'd0);
        measure(2'd2, cnt);
        chk("t2_fill_len", 32'(cnt), 32'd38);
        chk("t2_run_state", 32'(state), 32'd3);
        chk("t2_run_tvalid", 32'(m_axis_tvalid), 32'd1);
        filt_tvalid = 1'b0;
        #1;
        chk("t2_gate_low", 32'(m_axis_tvalid), 32'd0);
        filt_tvalid = 1'b1;
        step(1);

        // rejects
        cfg_drive(14'd2, 14'd20, 16'd5, 1'b0, 1'b1);
        step(1);
        cfg_pop("t3_k_small");
        chk("t3_state", 32'(state), 32'd3);
        q.push_back(resp_t'(2'b00));
        step(1);
        cfg_pop("t3_held");
        cfg_req = 1'b0;
        step(1);
        cfg_drive(14'd30, 14'd20, 16'd5, 1'b0, 1'b1);
        step(1);
        cfg_pop("t3_l_lt_k");
        cfg_req = 1'b0;
        step(1);
        chk("t3_state2", 32'(state), 32'd3);
        chk_filt("t3_filt", 10, 20, 0);

        // accept in RUN -> restart
        cfg_drive(14'd50, 14'd100, 16'd400, 1'b1, 1'b0);
        step(1);
        cfg_pop("t4_accept");
        cfg_req = 1'b0;
        chk("t4_restart", 32'(state), 32'd1);
        chk("t4_aresetn0", 32'(filt_aresetn), 32'd0);
        chk_filt("t4_old", 10, 20, 0);
        step(1);
        chk("t4_aresetn1", 32'(filt_aresetn), 32'd0);
        chk_filt("t4_new", 50, 100, 400);
        measure(2'd1, cnt);
        chk("t4_reset_rest", 32'(cnt), 32'd3);
        measure(2'd2, cnt);
        chk("t4_fill_len", 32'(cnt), 32'd158);
        chk("t4_run", 32'(state), 32'd3);

        // async reset mid-RUN
        #3;
        areset = 1'b1;
        #1;
        chk("t1_state", 32'(state), 32'd0);
        chk("t1_aresetn", 32'(filt_aresetn), 32'd0);
        chk("t1_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk_filt("t1_filt", 10, 20, 0);
        #1;
        areset = 1'b0;
        step(1);
        chk("t5_reset", 32'(state), 32'd1);
        measure(2'd1, cnt);
        chk("t5_reset_len", 32'(cnt), 32'd4);
        step(4);
        chk("t5_fill5", 32'(state), 32'd2);
        run_en = 1'b0;
        step(1);
        chk("t5_idle", 32'(state), 32'd0);
        chk("t5_aresetn", 32'(filt_aresetn), 32'd0);
        chk("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
        run_en = 1'b1;
        step(1);
        measure(2'd1, cnt);
        chk("t5_reset_len2", 32'(cnt), 32'd4);
        measure(2'd2, cnt);
        chk("t5_fill_len2", 32'(cnt), 32'd38);
        chk("t5_run_tvalid", 32'(m_axis_tvalid), 32'd1);

        // accept together with run_en drop
        cfg_drive(14'd5, 14'd7, 16'hFFFD, 1'b1, 1'b0);
        run_en = 1'b0;
        step(1);
        cfg_pop("t6_accept");
        cfg_req = 1'b0;
        chk("t6_idle", 32'(state), 32'd0);
        chk_filt("t6_old", 10, 20, 0);
        step(1);
        chk_filt("t6_new", 5, 7, 32'hFFFD);

        // boundary K=3, L=K accepted in IDLE
        cfg_drive(14'd3, 14'd3, 16'd1, 1'b1, 1'b0);
        step(1);
        cfg_pop("t7_accept");
        cfg_req = 1'b0;
        chk("t7_idle", 32'(state), 32'd0);
        step(1);
        chk_filt("t7_filt", 3, 3, 1);
        chk("t7_queue_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
